iformat_multicycle_cpu: RTL and testbench
=========================================

# iformat_multicycle_cpu

Multi-cycle successor to the single-cycle I-format CPU. It holds its own PC and executes a stream of MIPS I-format instructions from an internal instruction memory until it reaches a halt word or faults. Instruction memory, register file and data memory are internal and sized by parameters. A start/done handshake, a per-instruction retire pulse and a debug register read port let the bench drive and observe it without hierarchical probing.

## Interface
- `IM_WORDS`, 256: instruction memory depth in 32-bit words; power of two, at least 4.
- `DM_WORDS`, 256: data memory depth in 32-bit words; power of two, at least 4.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops execution without error.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin execution at `Input_Addr`; accepted only in IDLE or HALT.
- `Input_Addr`  in  32  byte address of the first instruction; sampled on an accepted `start`.
- `Output_Addr`  out  32  current PC (byte address).
- `busy`  out  1  high in every state except IDLE and HALT.
- `done`  out  1  high in HALT; cleared by an accepted `start` or by reset.
- `error`  out  1  valid while `done` is high; 1 means the halt was caused by a fault.
- `retire`  out  1  one-cycle pulse when an instruction commits.
- `dbg_sel`  in  5  register index for the debug read.
- `dbg_data`  out  32  combinational read of register `dbg_sel`; reads 0 when `dbg_sel` is 0.

## Operation
- Register file: 32 x 32. Register `$0` always reads 0, and writes to it are dropped. All registers clear on reset.
- Memories: IM and DM are word arrays with registered (synchronous) reads and synchronous writes. IM is preloaded by the bench. DM is not reset.
- Supported opcodes (bits [31:26]):
  - addi 0x08 and addiu 0x09: rt = rs + sext(imm). Both wrap modulo 2^32; there is no overflow trap.
  - slti 0x0A: signed compare. sltiu 0x0B: unsigned compare against sext(imm).
  - andi 0x0C and ori 0x0D: use zext(imm).
  - lui 0x0F: rt = {imm, 16'h0}.
  - lw 0x23 and sw 0x2B: address = rs + sext(imm).
  - beq 0x04 and bne 0x05: target = PC + 4 + (sext(imm) << 2).
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE → FETCH on `start`; PC is loaded from `Input_Addr`.
  - FETCH: if PC is misaligned or PC/4 >= IM_WORDS, go to HALT with a fault. Otherwise issue the IM read.
  - DECODE: latch IR and read rs and rt.
    - IR == HALT_WORD → HALT with no fault, no retire, PC unchanged.
    - Unknown opcode → HALT with a fault.
  - EXEC: compute the ALU result or address.
    - Branch: retire and update PC, then go to FETCH.
    - lw/sw: go to MEM.
    - Other instructions: go to WB.
  - MEM:
    - sw: address check; on success write, retire, PC += 4, go to FETCH.
    - lw: address check; on success issue the read and go to WB.
    - Address check fails if address[1:0] != 0 or address/4 >= DM_WORDS. A failure means HALT with a fault and no memory write.
  - WB: write rt (load data for lw, ALU result otherwise), retire, PC += 4, go to FETCH.
  - HALT → FETCH on `start`, with PC reloaded and `done`/`error` cleared.
- A `start` that arrives while `busy` is ignored.

## Timing
- Reset values:
  - State IDLE, PC 0, all registers 0.
  - `busy`, `done`, `error`, `retire` all 0.
  - `Output_Addr` 0.
- Cycles per instruction, from FETCH entry to commit:
  - Branch: 3.
  - ALU and lui: 4.
  - sw: 4.
  - lw: 5.
- Commit timing:
  - `retire` is asserted in the commit cycle.
  - The register, DM and PC updates are visible on the following edge.
- `done` rises on the edge that enters HALT. It is 2 cycles after FETCH entry for a halt word or illegal opcode, and 1 cycle for a fetch fault.
- `busy` rises on the edge after `start` is accepted.
- PC arithmetic is 32-bit and wraps. A wrapped PC is then caught by the FETCH range check.
- Asserting `rst_n` low in any state returns the block to IDLE at once. An in-flight write is lost and DM keeps its prior contents.

## Test plan
- ALU sequence: addi $1,$0,5; addi $2,$1,-7; slti $3,$2,0; sltiu $4,$2,1; lui $5,0x1234; ori $5,$5,0xABCD; andi $6,$5,0x00FF; halt. Required result:
  - $1=5, $2=0xFFFFFFFE, $3=1, $4=0, $5=0x1234ABCD, $6=0xCD.
  - `done`=1, `error`=0, 7 retire pulses, 28 cycles from FETCH to the last commit.
- Memory: sw $1,8($0); lw $7,8($0); addi $0,$0,9; halt. Required result: DM[2]=5, $7=5, dbg_sel 0 reads 0; sw takes 4 cycles and lw takes 5.
- Branches: a loop using addi/bne that counts $1 from 0 to 3, then beq $0,$0,+1 skipping an addi; halt. Required result: $1=3, the skipped register is unchanged, Output_Addr at HALT is the halt address.
- Faults:
  - lw with address 0x6 → `error`=1, `done`=1.
  - sw beyond DM_WORDS*4 → `error`=1 with DM unchanged.
  - Opcode 0x3F (not the halt word) → `error`=1.
  - start with Input_Addr = IM_WORDS*4 → `error`=1.
- Handshake: `start` pulsed while busy is ignored; `start` in HALT restarts at the new address and clears `done`/`error`.
- Reset: drop `rst_n` during the MEM state of sw. Required result: the FSM returns to IDLE, all registers read 0, and DM is unchanged.

Source files
------------

// File: rtl/iformat_multicycle_cpu.sv
// Multi-cycle MIPS I-format CPU with internal IM/DM and register file.
// It runs from a start address until a halt word is reached or a fault occurs.
module iformat_multicycle_cpu #(
  parameter int          IM_WORDS  = 256,
  parameter int          DM_WORDS  = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] Input_Addr,
  output logic [31:0] Output_Addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        retire,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);
  localparam int          IM_AW  = $clog2(IM_WORDS);
  localparam int          DM_AW  = $clog2(DM_WORDS);
  localparam logic [31:0] IM_LIM = 32'(IM_WORDS);
  localparam logic [31:0] DM_LIM = 32'(DM_WORDS);

  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        err, err_nx;

  logic [31:0] ir, a_q, b_q, alu_q, dm_q;
  logic [31:0] regs [32];
  logic [31:0] imem [IM_WORDS];
  logic [31:0] dmem [DM_WORDS];

  logic [5:0]         op;
  logic [4:0]         rt;
  logic signed [31:0] simm;
  logic [31:0]        zimm, pc_inc, br_tgt;
  logic               is_br, is_mem, is_sw, is_lw, op_ok, fetch_ok, dm_ok, br_taken;

  assign op     = ir[31:26];
  assign rt     = ir[20:16];
  assign simm   = $signed({{16{ir[15]}}, ir[15:0]});
  assign zimm   = {16'h0, ir[15:0]};
  assign pc_inc = pc + 32'd4;
  assign br_tgt = pc_inc + $unsigned(simm <<< 2);

  assign is_br    = (op == OP_BEQ) || (op == OP_BNE);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_mem   = is_lw || is_sw;
  assign br_taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  assign fetch_ok = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < IM_LIM);
  assign dm_ok    = (alu_q[1:0] == 2'b00) && ({2'b00, alu_q[31:2]} < DM_LIM);

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  function automatic logic [31:0] alu_f(input logic [5:0] opc, input logic [31:0] a,
                                        input logic signed [31:0] si, input logic [31:0] zi,
                                        input logic [15:0] imm);
    logic signed [31:0] sa;
    sa = $signed(a);
    case (opc)
      OP_SLTI:  alu_f = (sa < si) ? 32'd1 : 32'd0;
      OP_SLTIU: alu_f = (a < $unsigned(si)) ? 32'd1 : 32'd0;
      OP_ANDI:  alu_f = a & zi;
      OP_ORI:   alu_f = a | zi;
      OP_LUI:   alu_f = {imm, 16'h0};
      default:  alu_f = a + $unsigned(si);
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    err_nx   = err;
    retire   = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = Input_Addr;
          err_nx   = 1'b0;
        end
      end
      S_FETCH: begin
        if (fetch_ok) state_nx = S_DECODE;
        else begin
          state_nx = S_HALT;
          err_nx   = 1'b1;
        end
      end
      S_DECODE: begin
        if (ir == HALT_WORD) state_nx = S_HALT;
        else if (!op_ok) begin
          state_nx = S_HALT;
          err_nx   = 1'b1;
        end else state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (is_br) begin
          retire   = 1'b1;
          pc_nx    = br_taken ? br_tgt : pc_inc;
          state_nx = S_FETCH;
        end else if (is_mem) state_nx = S_MEM;
        else state_nx = S_WB;
      end
      S_MEM: begin
        if (!dm_ok) begin
          state_nx = S_HALT;
          err_nx   = 1'b1;
        end else if (is_sw) begin
          retire   = 1'b1;
          pc_nx    = pc_inc;
          state_nx = S_FETCH;
        end else state_nx = S_WB;
      end
      S_WB: begin
        retire   = 1'b1;
        pc_nx    = pc_inc;
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= 32'h0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      err   <= err_nx;
    end
  end

  // Datapath registers and memories; no reset so DM survives a reset.
  always_ff @(posedge clk) begin
    if (state == S_FETCH) ir <= imem[pc[IM_AW+1:2]];
    if (state == S_DECODE) begin
      a_q <= regs[ir[25:21]];
      b_q <= regs[ir[20:16]];
    end
    if (state == S_EXEC) alu_q <= alu_f(op, a_q, simm, zimm, ir[15:0]);
    if (state == S_MEM) begin
      dm_q <= dmem[alu_q[DM_AW+1:2]];
      if (is_sw && dm_ok) dmem[alu_q[DM_AW+1:2]] <= b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (state == S_WB && rt != 5'd0) begin
      regs[rt] <= is_lw ? dm_q : alu_q;
    end
  end

  assign Output_Addr = pc;
  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign done        = (state == S_HALT);
  assign error       = err;
  assign dbg_data    = (dbg_sel == 5'd0) ? 32'h0 : regs[dbg_sel];

endmodule

// File: tb/tb_iformat_multicycle_cpu.sv
// Bench for iformat_multicycle_cpu: an ISA-level model predicts the retire/done
// timeline, final registers, PC and DM; literal values pin the model.
module tb_iformat_multicycle_cpu;
  localparam int          IMW  = 256;
  localparam int          DMW  = 256;
  localparam int          MAXC = 400;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] Input_Addr = 32'h0;
  logic [31:0] Output_Addr;
  logic        busy, done, error, retire;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data;

  iformat_multicycle_cpu #(.IM_WORDS(IMW), .DM_WORDS(DMW), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Input_Addr(Input_Addr),
    .Output_Addr(Output_Addr), .busy(busy), .done(done), .error(error),
    .retire(retire), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] tb_im [IMW];
  logic [31:0] m_reg [32];
  logic [31:0] m_dm  [DMW];
  bit          m_dmv [DMW];
  bit          exp_ret [MAXC+1];
  int          m_done_cyc;
  bit          m_err;
  logic [31:0] m_pc;
  int          obs_ret [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ii(input logic [5:0] op, input int rs, input int rt,
                                     input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  task automatic rd(input int r, output logic [31:0] v);
    dbg_sel = 5'(r);
    #1;
    v = dbg_data;
  endtask

  // Instruction-level interpreter; cycle 1 is the first FETCH cycle.
  task automatic model_run(input logic [31:0] a);
    logic [31:0]        pc, w, rsv, rtv, ea;
    logic signed [31:0] se;
    logic [5:0]         op;
    int                 cyc, cpi;
    bit                 stop, taken;
    for (int i = 0; i <= MAXC; i++) exp_ret[i] = 1'b0;
    pc = a; cyc = 1; m_err = 1'b0; m_done_cyc = MAXC + 1;
    while (cyc <= MAXC) begin
      stop = 1'b0; taken = 1'b0; cpi = 4;
      if (pc % 4 != 0 || pc / 4 >= IMW) begin
        m_err = 1'b1; m_done_cyc = cyc + 1; break;
      end
      w = tb_im[pc / 4];
      if (w == HALT) begin
        m_done_cyc = cyc + 2; break;
      end
      op  = w[31:26];
      rsv = m_reg[w[25:21]];
      rtv = m_reg[w[20:16]];
      se  = $signed({{16{w[15]}}, w[15:0]});
      ea  = rsv + se;
      case (op)
        6'h08, 6'h09: wr(w[20:16], rsv + se);
        6'h0A: wr(w[20:16], ($signed(rsv) < se) ? 32'd1 : 32'd0);
        6'h0B: wr(w[20:16], (rsv < $unsigned(se)) ? 32'd1 : 32'd0);
        6'h0C: wr(w[20:16], rsv & {16'h0, w[15:0]});
        6'h0D: wr(w[20:16], rsv | {16'h0, w[15:0]});
        6'h0F: wr(w[20:16], {w[15:0], 16'h0});
        6'h04, 6'h05: begin
          cpi = 3;
          if ((op == 6'h04) == (rsv == rtv)) begin
            taken = 1'b1;
            pc = pc + 4 + (se * 4);
          end
        end
        6'h23: begin
          cpi = 5;
          if (ea % 4 != 0 || ea / 4 >= DMW) begin
            m_err = 1'b1; m_done_cyc = cyc + 4; stop = 1'b1;
          end else wr(w[20:16], m_dm[ea / 4]);
        end
        6'h2B: begin
          if (ea % 4 != 0 || ea / 4 >= DMW) begin
            m_err = 1'b1; m_done_cyc = cyc + 4; stop = 1'b1;
          end else begin
            m_dm[ea / 4] = rtv; m_dmv[ea / 4] = 1'b1;
          end
        end
        default: begin
          m_err = 1'b1; m_done_cyc = cyc + 2; stop = 1'b1;
        end
      endcase
      if (stop) break;
      if (cyc + cpi - 1 <= MAXC) exp_ret[cyc + cpi - 1] = 1'b1;
      cyc = cyc + cpi;
      if (!taken && !(op == 6'h04 || op == 6'h05)) pc = pc + 4;
      else if (!taken) pc = pc + 4;
    end
    m_pc = pc;
  endtask

  task automatic run_prog(input string tag, input logic [31:0] a, input int spur);
    bit          seen_done;
    int          bad;
    logic [31:0] v;
    model_run(a);
    obs_ret.delete();
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; Input_Addr = a;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      start = (c == spur);
      if (c == spur) Input_Addr = 32'h0;
      chk($sformatf("%s retire@%0d", tag, c), {31'b0, retire}, {31'b0, exp_ret[c]});
      chk($sformatf("%s busy@%0d", tag, c), {31'b0, busy}, {31'b0, (c < m_done_cyc)});
      chk($sformatf("%s done@%0d", tag, c), {31'b0, done}, {31'b0, (c >= m_done_cyc)});
      if (c == 1) chk($sformatf("%s error cleared", tag), {31'b0, error}, 32'h0);
      if (retire) obs_ret.push_back(c);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen_done) begin
      tests++; fails++;
      $display("FAIL %s timeout: done not seen, expected at cycle %0d", tag, m_done_cyc);
    end
    chk($sformatf("%s error", tag), {31'b0, error}, {31'b0, m_err});
    chk($sformatf("%s pc", tag), Output_Addr, m_pc);
    for (int r = 0; r < 32; r++) begin
      rd(r, v);
      chk($sformatf("%s reg%0d", tag, r), v, (r == 0) ? 32'h0 : m_reg[r]);
    end
    bad = 0;
    for (int i = 0; i < DMW; i++)
      if (m_dmv[i] && dut.dmem[i] !== m_dm[i]) bad++;
    chk($sformatf("%s dm words differing", tag), 32'(bad), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < IMW; i++) tb_im[i] = HALT;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    for (int i = 0; i < DMW; i++) begin m_dm[i] = 32'h0; m_dmv[i] = 1'b0; end
    // ALU sequence at 0x00
    tb_im[0] = ii(6'h08, 0, 1, 16'd5);
    tb_im[1] = ii(6'h08, 1, 2, 16'hFFF9);
    tb_im[2] = ii(6'h0A, 2, 3, 16'h0000);
    tb_im[3] = ii(6'h0B, 2, 4, 16'h0001);
    tb_im[4] = ii(6'h0F, 0, 5, 16'h1234);
    tb_im[5] = ii(6'h0D, 5, 5, 16'hABCD);
    tb_im[6] = ii(6'h0C, 5, 6, 16'h00FF);
    // Memory at 0x40
    tb_im[16] = ii(6'h2B, 0, 1, 16'd8);
    tb_im[17] = ii(6'h23, 0, 7, 16'd8);
    tb_im[18] = ii(6'h08, 0, 0, 16'd9);
    // Branch loop at 0x80
    tb_im[32] = ii(6'h08, 0, 9, 16'd3);
    tb_im[33] = ii(6'h08, 0, 1, 16'd0);
    tb_im[34] = ii(6'h08, 1, 1, 16'd1);
    tb_im[35] = ii(6'h05, 1, 9, 16'hFFFE);
    tb_im[36] = ii(6'h04, 0, 0, 16'd1);
    tb_im[37] = ii(6'h08, 0, 10, 16'h0077);
    // Faults
    tb_im[48] = ii(6'h23, 0, 8, 16'd6);
    tb_im[50] = ii(6'h2B, 0, 0, 16'd0);
    tb_im[51] = ii(6'h2B, 0, 1, 16'h0400);
    tb_im[52] = 32'hFC00_0000;
    // Reset during sw
    tb_im[56] = ii(6'h2B, 0, 0, 16'd12);
    tb_im[57] = ii(6'h2B, 0, 1, 16'd12);
    for (int i = 0; i < IMW; i++) dut.imem[i] = tb_im[i];

    #12;
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset error", {31'b0, error}, 32'h0);
    chk("reset retire", {31'b0, retire}, 32'h0);
    chk("reset pc", Output_Addr, 32'h0);
    rd(1, v); chk("reset reg1", v, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_prog("alu", 32'h0, 0);
    rd(1, v); chk("alu lit $1", v, 32'd5);
    rd(2, v); chk("alu lit $2", v, 32'hFFFF_FFFE);
    rd(3, v); chk("alu lit $3", v, 32'd1);
    rd(4, v); chk("alu lit $4", v, 32'd0);
    rd(5, v); chk("alu lit $5", v, 32'h1234_ABCD);
    rd(6, v); chk("alu lit $6", v, 32'h0000_00CD);
    chk("alu lit retire count", 32'(obs_ret.size()), 32'd7);
    if (obs_ret.size() > 0) chk("alu lit last commit", 32'(obs_ret[obs_ret.size()-1]), 32'd28);
    chk("alu lit done", {31'b0, done}, 32'h1);
    chk("alu lit error", {31'b0, error}, 32'h0);

    run_prog("mem", 32'h40, 0);
    chk("mem lit DM[2]", dut.dmem[2], 32'd5);
    rd(7, v); chk("mem lit $7", v, 32'd5);
    rd(0, v); chk("mem lit $0", v, 32'd0);
    chk("mem lit retire count", 32'(obs_ret.size()), 32'd3);
    if (obs_ret.size() >= 2) begin
      chk("mem lit sw commit", 32'(obs_ret[0]), 32'd4);
      chk("mem lit lw commit", 32'(obs_ret[1]), 32'd9);
    end

    run_prog("branch", 32'h80, 3);
    rd(1, v);  chk("branch lit $1", v, 32'd3);
    rd(10, v); chk("branch lit $10", v, 32'd0);
    chk("branch lit pc", Output_Addr, 32'h98);

    run_prog("lw_misalign", 32'd192, 0);
    chk("lw_misalign lit error", {31'b0, error}, 32'h1);
    run_prog("sw_range", 32'd200, 0);
    chk("sw_range lit error", {31'b0, error}, 32'h1);
    chk("sw_range lit DM[0]", dut.dmem[0], 32'h0);
    run_prog("bad_op", 32'd208, 0);
    chk("bad_op lit error", {31'b0, error}, 32'h1);
    run_prog("fetch_range", 32'(IMW * 4), 0);
    chk("fetch_range lit error", {31'b0, error}, 32'h1);

    run_prog("restart", 32'h40, 0);
    chk("restart lit DM[2]", dut.dmem[2], 32'd3);
    rd(7, v); chk("restart lit $7", v, 32'd3);
    chk("restart lit error", {31'b0, error}, 32'h0);

    // Reset asserted during the MEM cycle of the second sw (cycle 8)
    @(negedge clk);
    start = 1'b1; Input_Addr = 32'hE0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rst sw commit cycle", {31'b0, retire}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst done", {31'b0, done}, 32'h0);
    chk("rst error", {31'b0, error}, 32'h0);
    chk("rst retire", {31'b0, retire}, 32'h0);
    chk("rst pc", Output_Addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int r = 1; r < 32; r++) begin
      rd(r, v);
      chk($sformatf("rst reg%0d", r), v, 32'h0);
    end
    chk("rst DM[3]", dut.dmem[3], 32'h0);
    chk("rst DM[2]", dut.dmem[2], 32'd3);
    chk("rst idle busy", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
